// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter state encoding and divisor limits.
package mmio_pkg;

  // Register offsets inside the 16-byte window (address bits [3:0], [1:0] forced to 0)
  localparam logic [3:0] OFF_TXDATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_DIVISOR  = 4'h8;
  localparam logic [3:0] OFF_RESERVED = 4'hC;

  // STATUS word layout
  localparam int ST_FULL_BIT  = 0;
  localparam int ST_EMPTY_BIT = 1;
  localparam int ST_BUSY_BIT  = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

  // Bit-time divisor: 50 MHz / 115200 after reset; anything below 2 is clamped
  localparam logic [15:0] RESET_DIVISOR = 16'd434;
  localparam logic [15:0] MIN_DIVISOR   = 16'd2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // A divisor of 0 or 1 would make a bit shorter than the timer can express
  function automatic logic [15:0] clamp_divisor(input logic [15:0] value);
    return (value < MIN_DIVISOR) ? MIN_DIVISOR : value;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting for transmission. The head
// entry is visible combinationally so the transmitter can pop it on the same
// edge it decides to start a frame. Callers never push when full or pop when
// empty; the dropped-push policy lives in the parent.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  // Storage array: written at the tail, no reset needed since count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory port. Decodes a
// 16-byte window, queues TXDATA stores in a FIFO and shifts them out LSB first.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h1001_0100,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = RESET_DIVISOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  output logic        sel_o,
  output logic [31:0] data_o,
  output logic        tx_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    offset;
  logic          wr_txdata;
  logic          wr_divisor;
  logic          rd_status;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_dout;
  logic          push_dropped;
  logic          overflow_reg;
  logic [15:0]   divisor_reg;
  tx_state_e     state_reg;
  tx_state_e     state_next;
  logic [15:0]   timer_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          bit_done;
  logic          timer_reload;
  logic          shift_en;
  logic          busy;
  logic [3:0]    count_sat;
  logic [31:0]   status_word;
  logic          unused_bits;

  assign sel_o      = (address_i[31:4] == BASE_ADDR[31:4]);
  assign offset     = {address_i[3:2], 2'b00};
  assign wr_txdata  = sel_o & mem_write_i & (offset == OFF_TXDATA);
  assign wr_divisor = sel_o & mem_write_i & (offset == OFF_DIVISOR);
  assign rd_status  = sel_o & mem_read_i  & (offset == OFF_STATUS);

  // Fullness is judged before any same-edge pop, so a push into a full FIFO is lost
  assign fifo_push    = wr_txdata & ~fifo_full;
  assign push_dropped = wr_txdata & fifo_full;

  assign unused_bits = ^{address_i[1:0], write_data_i[31:16]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (write_data_i[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overflow flag; a dropped push on the same edge beats the read-clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            overflow_reg <= 1'b0;
    else if (push_dropped) overflow_reg <= 1'b1;
    else if (rd_status)    overflow_reg <= 1'b0;
  end

  // Divisor register; only consulted at the next timer reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          divisor_reg <= DEFAULT_DIVISOR;
    else if (wr_divisor) divisor_reg <= clamp_divisor(write_data_i[15:0]);
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= TX_IDLE;
    else        state_reg <= state_next;
  end

  assign bit_done = (timer_reg == 16'd0);

  // Bit timer, shift register and data-bit counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_reg   <= 16'd0;
      bit_idx_reg <= 3'd0;
      shift_reg   <= 8'd0;
    end else begin
      if (timer_reload)   timer_reg <= divisor_reg - 16'd1;
      else if (!bit_done) timer_reg <= timer_reg - 16'd1;

      if (fifo_pop)       shift_reg <= fifo_dout;
      else if (shift_en)  shift_reg <= {1'b0, shift_reg[7:1]};

      if (state_reg == TX_START) bit_idx_reg <= 3'd0;
      else if (shift_en)         bit_idx_reg <= bit_idx_reg + 3'd1;
    end
  end

  // Next-state, pop/reload strobes and line level; STOP chains straight into START
  always_comb begin
    state_next   = state_reg;
    fifo_pop     = 1'b0;
    timer_reload = 1'b0;
    shift_en     = 1'b0;
    tx_o         = 1'b1;
    case (state_reg)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          timer_reload = 1'b1;
          state_next   = TX_START;
        end
      end
      TX_START: begin
        tx_o = 1'b0;
        if (bit_done) begin
          timer_reload = 1'b1;
          state_next   = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_o = shift_reg[0];
        if (bit_done) begin
          shift_en     = 1'b1;
          timer_reload = 1'b1;
          if (bit_idx_reg == 3'd7) state_next = TX_STOP;
        end
      end
      TX_STOP: begin
        tx_o = 1'b1;
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            timer_reload = 1'b1;
            state_next   = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: state_next = TX_IDLE;
    endcase
  end

  assign busy = (state_reg != TX_IDLE);

  // STATUS assembly with the FIFO count saturated into a 4-bit field
  always_comb begin
    if (32'(fifo_count) > 32'd15) count_sat = 4'hF;
    else                          count_sat = 4'(fifo_count);
    status_word                    = 32'd0;
    status_word[ST_FULL_BIT]       = fifo_full;
    status_word[ST_EMPTY_BIT]      = fifo_empty;
    status_word[ST_BUSY_BIT]       = busy;
    status_word[ST_OVF_BIT]        = overflow_reg;
    status_word[ST_CNT_LSB +: 4]   = count_sat;
  end

  // Zero-latency load mux; unselected or non-load cycles return 0
  always_comb begin
    data_o = 32'd0;
    if (sel_o && mem_read_i) begin
      case (offset)
        OFF_STATUS:               data_o = status_word;
        OFF_DIVISOR:              data_o = {16'd0, divisor_reg};
        OFF_TXDATA, OFF_RESERVED: data_o = 32'd0;
        default:                  data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow, window decode and asynchronous reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h1001_0100;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;
  localparam logic [31:0] A_RSV = BASE + 32'hC;
  localparam logic [31:0] A_OUT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic        sel_o;
  logic [31:0] data_o;
  logic        tx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .address_i    (address),
    .write_data_i (wdata),
    .mem_write_i  (mem_write),
    .mem_read_i   (mem_read),
    .sel_o        (sel_o),
    .data_o       (data_o),
    .tx_o         (tx_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Store: commits on the next rising edge, returns 1 ns after it
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    address   = a;
    wdata     = d;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    $display("WR  %08h <= %08h", a, d);
  endtask

  // Load that spans a clock edge (so side effects such as overflow clear happen)
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    address  = a;
    mem_read = 1'b1;
    #1;
    d = data_o;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    $display("RD  %08h => %08h", a, d);
  endtask

  // Combinational look at the read port without crossing an edge
  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    address  = a;
    mem_read = 1'b1;
    #1;
    d = data_o;
    mem_read = 1'b0;
    $display("PK  %08h => %08h", a, d);
  endtask

  // 40 samples of one frame at DIVISOR = 4: start, 8 data bits LSB first, stop
  task automatic check_frame(input logic [7:0] b, input bit now);
    logic exp_bit;
    int   idx;
    for (int k = 0; k < 40; k++) begin
      if (!(k == 0 && now)) begin
        @(posedge clk);
        #1;
      end
      idx = k / 4;
      if (idx == 0)      exp_bit = 1'b0;
      else if (idx == 9) exp_bit = 1'b1;
      else               exp_bit = b[idx-1];
      check($sformatf("tx_%02h_c%0d", b, k), {31'd0, tx_o}, {31'd0, exp_bit});
    end
    $display("FRM %02h checked", b);
  endtask

  initial begin
    logic [31:0] d;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("tx_in_reset", {31'd0, tx_o}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("tx_idle", {31'd0, tx_o}, 32'd1);
    peek(A_ST, d);
    check("status_reset", d, 32'h0000_0002);
    peek(A_DIV, d);
    check("divisor_reset", d, 32'd434);
    check("sel_in_window", {31'd0, sel_o}, 32'd1);

    // Single frame of 0x55
    bus_write(A_DIV, 32'd4);
    peek(A_DIV, d);
    check("divisor_4", d, 32'd4);
    bus_write(A_TX, 32'h0000_0055);
    check("tx_before_pop", {31'd0, tx_o}, 32'd1);
    check_frame(8'h55, 1'b0);
    peek(A_ST, d);
    check("status_in_stop", d, 32'h0000_0006);
    @(posedge clk);
    #1;
    peek(A_ST, d);
    check("status_after_frame", d, 32'h0000_0002);

    // Back-to-back frames with no idle gap
    bus_write(A_TX, 32'h0000_00A5);
    bus_write(A_TX, 32'h0000_003C);
    check_frame(8'hA5, 1'b1);
    check_frame(8'h3C, 1'b0);
    @(posedge clk);
    #1;
    peek(A_ST, d);
    check("status_after_pair", d, 32'h0000_0002);

    // Ten pushes: first is popped, eight fill the FIFO, tenth is dropped
    for (int i = 0; i < 10; i++) bus_write(A_TX, 32'h11 + 32'(i));
    peek(A_ST, d);
    check("status_full_ovf", d, 32'h0000_008D);
    bus_read(A_ST, d);
    check("status_read_clr", d, 32'h0000_008D);
    peek(A_ST, d);
    check("status_ovf_cleared", d, 32'h0000_0085);
    repeat (30) @(posedge clk);
    #1;
    for (int i = 1; i < 9; i++) check_frame(8'(8'h11 + i), 1'b0);
    @(posedge clk);
    #1;
    peek(A_ST, d);
    check("status_drained", d, 32'h0000_0002);
    check("tx_drained", {31'd0, tx_o}, 32'd1);

    // Window decode and divisor clamp
    peek(A_OUT, d);
    check("data_outside", d, 32'd0);
    check("sel_outside", {31'd0, sel_o}, 32'd0);
    bus_write(A_OUT, 32'h0000_0077);
    bus_write(BASE + 32'h18, 32'd9);
    peek(A_ST, d);
    check("status_after_outside", d, 32'h0000_0002);
    peek(A_DIV, d);
    check("divisor_untouched", d, 32'd4);
    bus_write(A_RSV, 32'hFFFF_FFFF);
    peek(A_RSV, d);
    check("reserved_reads_0", d, 32'd0);
    peek(A_TX, d);
    check("txdata_reads_0", d, 32'd0);
    check("tx_after_rsv", {31'd0, tx_o}, 32'd1);
    bus_write(A_DIV, 32'd0);
    peek(A_DIV, d);
    check("divisor_0_clamp", d, 32'd2);
    bus_write(A_DIV, 32'hABCD_0001);
    peek(A_DIV, d);
    check("divisor_1_clamp", d, 32'd2);
    bus_write(A_DIV, 32'd4);

    // Asynchronous reset in the middle of the data bits
    bus_write(A_TX, 32'h0000_00F0);
    bus_write(A_TX, 32'h0000_000F);
    repeat (6) @(posedge clk);
    #1;
    check("tx_mid_data", {31'd0, tx_o}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("tx_async_reset", {31'd0, tx_o}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    peek(A_ST, d);
    check("status_after_reset", d, 32'h0000_0002);
    peek(A_DIV, d);
    check("divisor_after_reset", d, 32'd434);
    repeat (50) @(posedge clk);
    #1;
    check("tx_idle_after_reset", {31'd0, tx_o}, 32'd1);
    peek(A_ST, d);
    check("status_still_idle", d, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
